// File: rtl/rom_rr_arbiter_if.sv
// Bundle between table-lookup clients, the round-robin ROM arbiter and the ROM port.
// The master side drives requests and returns ROM data; the slave side is the arbiter.
interface rom_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_rdy;
  logic [NUM_REQ-1:0]            rsp_vld;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rom_addr_vld;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic                          rom_dout_vld;
  logic [DATA_WIDTH-1:0]         rom_dout;

  modport master (
    output req_vld, req_addr, rom_dout_vld, rom_dout,
    input  req_rdy, rsp_vld, rsp_data, rom_addr_vld, rom_addr
  );

  modport slave (
    input  req_vld, req_addr, rom_dout_vld, rom_dout,
    output req_rdy, rsp_vld, rsp_data, rom_addr_vld, rom_addr
  );
endinterface

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM between NUM_REQ requesters.
// A registered tag remembers the owner of the in-flight read so the returned word is routed back.
module rom_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input logic             clk,
  input logic             rst,
  rom_rr_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   inflight_tag;
  logic               inflight_vld;
  logic               chk_armed;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               gnt_any;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_onehot;

  // Scan from rr_ptr with an explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr) + k >= NUM_REQ)
        cand = PTR_W'(int'(rr_ptr) + k - NUM_REQ);
      else
        cand = PTR_W'(int'(rr_ptr) + k);
      if (!gnt_any && !rst && bus.req_vld[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any)
      grant[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  assign bus.req_rdy      = grant;
  assign bus.rom_addr_vld = gnt_any;
  assign bus.rom_addr     = gnt_any ? bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      inflight_vld <= 1'b0;
      inflight_tag <= '0;
      chk_armed    <= 1'b0;
    end else begin
      inflight_vld <= gnt_any;
      chk_armed    <= 1'b1;
      if (gnt_any) begin
        rr_ptr       <= ptr_nxt;
        inflight_tag <= gnt_idx;
      end
    end
  end

  // The ROM's own valid is not reset, so the response qualifier comes from our tag pipeline.
  always_comb begin
    rsp_onehot = '0;
    if (inflight_vld)
      rsp_onehot[inflight_tag] = 1'b1;
  end

  assign bus.rsp_vld  = rsp_onehot;
  assign bus.rsp_data = bus.rom_dout;

  a_rom_vld_tracks: assert property (@(posedge clk) disable iff (rst)
    chk_armed |-> (inflight_vld == bus.rom_dout_vld));
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter with a behavioural ROM holding mem[a] = a + 0x1000.
module tb_rom_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rom_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rom_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: 1-cycle latency, valid not reset.
  always @(posedge clk) begin
    bus.rom_dout_vld <= bus.rom_addr_vld;
    bus.rom_dout     <= 32'(bus.rom_addr) + 32'h1000;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.req_vld  = 4'b1111;
    bus.req_addr = {12'h040, 12'h030, 12'h020, 12'h010};
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.req_rdy !== 4'b0000) begin
      n_err++; $display("FAIL rst_req_rdy got %b want 0000", bus.req_rdy);
    end
    n_cmp++;
    if (bus.rom_addr_vld !== 1'b0) begin
      n_err++; $display("FAIL rst_rom_addr_vld got %b want 0", bus.rom_addr_vld);
    end
    n_cmp++;
    if (bus.rsp_vld !== 4'b0000) begin
      n_err++; $display("FAIL rst_rsp_vld got %b want 0000", bus.rsp_vld);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b0001) begin
      n_err++; $display("FAIL first_grant got %b want 0001", bus.req_rdy);
    end
  endtask

  task automatic test_full_contention();
    int prev;
    prev = -1;
    for (int c = 0; c < 8; c++) begin
      bus.req_vld = 4'b1111;
      #1;
      n_cmp++;
      if (bus.req_rdy !== (4'b0001 << (c % 4))) begin
        n_err++; $display("FAIL full_grant c=%0d got %b want %b", c, bus.req_rdy, 4'b0001 << (c % 4));
      end
      n_cmp++;
      if (bus.rom_addr !== 12'((c % 4 + 1) * 16)) begin
        n_err++; $display("FAIL full_rom_addr c=%0d got %h want %h", c, bus.rom_addr, (c % 4 + 1) * 16);
      end
      if (prev >= 0) begin
        n_cmp++;
        if (bus.rsp_vld !== (4'b0001 << prev)) begin
          n_err++; $display("FAIL full_rsp_vld c=%0d got %b want %b", c, bus.rsp_vld, 4'b0001 << prev);
        end
        n_cmp++;
        if (bus.rsp_data !== 32'(32'h1000 + (prev + 1) * 16)) begin
          n_err++; $display("FAIL full_rsp_data c=%0d got %h want %h", c, bus.rsp_data, 32'h1000 + (prev + 1) * 16);
        end
      end
      prev = c % 4;
      next_cycle();
    end
    bus.req_vld = 4'b0000;
    #1;
    n_cmp++;
    if (bus.rsp_vld !== 4'b1000 || bus.rsp_data !== 32'h1040) begin
      n_err++; $display("FAIL full_drain got %b/%h want 1000/00001040", bus.rsp_vld, bus.rsp_data);
    end
    n_cmp++;
    if (bus.rom_addr_vld !== 1'b0 || bus.req_rdy !== 4'b0000) begin
      n_err++; $display("FAIL full_drain_issue got vld=%b rdy=%b want 0/0000", bus.rom_addr_vld, bus.req_rdy);
    end
    next_cycle();
  endtask

  // Pointer is 0 here; ends with rr_ptr = 3.
  task automatic test_sparse();
    bus.req_addr = {12'h040, 12'h7FF, 12'h020, 12'h010};
    for (int c = 0; c < 3; c++) begin
      bus.req_vld = 4'b0100;
      #1;
      n_cmp++;
      if (bus.req_rdy !== 4'b0100 || bus.rom_addr !== 12'h7FF) begin
        n_err++; $display("FAIL sparse_grant c=%0d got %b/%h want 0100/7ff", c, bus.req_rdy, bus.rom_addr);
      end
      if (c > 0) begin
        n_cmp++;
        if (bus.rsp_vld !== 4'b0100 || bus.rsp_data !== 32'h17FF) begin
          n_err++; $display("FAIL sparse_rsp c=%0d got %b/%h want 0100/000017ff", c, bus.rsp_vld, bus.rsp_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fairness();
    bus.req_vld = 4'b1111;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b1000) begin
      n_err++; $display("FAIL fair_ptr3 got %b want 1000", bus.req_rdy);
    end
    n_cmp++;
    if (bus.rsp_vld !== 4'b0100 || bus.rsp_data !== 32'h17FF) begin
      n_err++; $display("FAIL sparse_rsp_last got %b/%h want 0100/000017ff", bus.rsp_vld, bus.rsp_data);
    end
    next_cycle();
    bus.req_addr = {12'h040, 12'h030, 12'h020, 12'h010};
    bus.req_vld  = 4'b1010;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b0010) begin
      n_err++; $display("FAIL fair_wrap_first got %b want 0010", bus.req_rdy);
    end
    n_cmp++;
    if (bus.rsp_vld !== 4'b1000 || bus.rsp_data !== 32'h1040) begin
      n_err++; $display("FAIL fair_rsp3 got %b/%h want 1000/00001040", bus.rsp_vld, bus.rsp_data);
    end
    next_cycle();
    bus.req_vld = 4'b1010;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b1000 || bus.rom_addr !== 12'h040) begin
      n_err++; $display("FAIL fair_second got %b/%h want 1000/040", bus.req_rdy, bus.rom_addr);
    end
    n_cmp++;
    if (bus.rsp_vld !== 4'b0010 || bus.rsp_data !== 32'h1020) begin
      n_err++; $display("FAIL fair_rsp1 got %b/%h want 0010/00001020", bus.rsp_vld, bus.rsp_data);
    end
    next_cycle();
  endtask

  // Pointer is 0 here (last grant was req 3).
  task automatic test_idle_gap();
    for (int c = 0; c < 5; c++) begin
      bus.req_vld = 4'b0000;
      #1;
      if (c == 0) begin
        n_cmp++;
        if (bus.rsp_vld !== 4'b1000) begin
          n_err++; $display("FAIL idle_drain got %b want 1000", bus.rsp_vld);
        end
      end else begin
        n_cmp++;
        if (bus.rsp_vld !== 4'b0000) begin
          n_err++; $display("FAIL idle_rsp c=%0d got %b want 0000", c, bus.rsp_vld);
        end
      end
      n_cmp++;
      if (bus.rom_addr_vld !== 1'b0 || bus.rom_addr !== 12'h000) begin
        n_err++; $display("FAIL idle_issue c=%0d got %b/%h want 0/000", c, bus.rom_addr_vld, bus.rom_addr);
      end
      next_cycle();
    end
    bus.req_vld = 4'b1111;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b0001) begin
      n_err++; $display("FAIL idle_ptr_hold got %b want 0001", bus.req_rdy);
    end
    next_cycle();
  endtask

  // Pointer is 1 here; accept req 1, then reset during the response cycle.
  task automatic test_reset_midflight();
    bus.req_vld = 4'b0010;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b0010) begin
      n_err++; $display("FAIL mid_grant got %b want 0010", bus.req_rdy);
    end
    @(posedge clk);
    #1;
    bus.req_vld = 4'b1111;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.rsp_vld !== 4'b0000) begin
      n_err++; $display("FAIL mid_rsp_dropped got %b want 0000", bus.rsp_vld);
    end
    n_cmp++;
    if (bus.req_rdy !== 4'b0000 || bus.rom_addr_vld !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_issue got %b/%b want 0000/0", bus.req_rdy, bus.rom_addr_vld);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_rdy !== 4'b0001 || bus.rsp_vld !== 4'b0000) begin
      n_err++; $display("FAIL mid_after_rst got %b/%b want 0001/0000", bus.req_rdy, bus.rsp_vld);
    end
    next_cycle();
    bus.req_vld = 4'b0000;
    #1;
    n_cmp++;
    if (bus.rsp_vld !== 4'b0001 || bus.rsp_data !== 32'h1010) begin
      n_err++; $display("FAIL mid_next_rsp got %b/%h want 0001/00001010", bus.rsp_vld, bus.rsp_data);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (bus.rsp_vld !== 4'b0000) begin
      n_err++; $display("FAIL mid_quiet got %b want 0000", bus.rsp_vld);
    end
  endtask

  initial begin
    test_reset();
    test_full_contention();
    test_sparse();
    test_fairness();
    test_idle_gap();
    test_reset_midflight();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
